// File: rtl/tetris_pkg.sv
// ============================================================================
// tetris_pkg : button bit map, tetrimino type codes, lateral-conflict filter
// Rev 1.0
// ============================================================================
`default_nettype none

package tetris_pkg;

    localparam int NUM_BTN = 5;

    localparam int RIGHT  = 0;
    localparam int LEFT   = 1;
    localparam int DOWN   = 2;
    localparam int ROTATE = 3;
    localparam int START  = 4;

    localparam logic [2:0] TYPE_I = 3'd0;
    localparam logic [2:0] TYPE_O = 3'd1;
    localparam logic [2:0] TYPE_T = 3'd2;
    localparam logic [2:0] TYPE_S = 3'd3;
    localparam logic [2:0] TYPE_Z = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;
    localparam logic [2:0] TYPE_L = 3'd6;

    // Opposed lateral moves cancel each other; other bits pass through.
    function automatic logic [NUM_BTN-1:0] filter_lateral(input logic [NUM_BTN-1:0] ev);
        logic [NUM_BTN-1:0] f;
        f = ev;
        if (ev[RIGHT] && ev[LEFT]) begin
            f[RIGHT] = 1'b0;
            f[LEFT]  = 1'b0;
        end
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce : 2-flop synchroniser, stability counter, press pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_press;
    logic [15:0] r_count;
    logic        w_differ;
    logic        w_expired;

    assign w_differ  = (r_sync2 != r_level);
    assign w_expired = (r_count == DEBOUNCE_CYCLES - 16'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_count <= 16'd0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (!w_differ) begin
                r_count <= 16'd0;
            end else if (w_expired) begin
                // Level accepted; the pulse coincides with the first cycle of the new level.
                r_count <= 16'd0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// input_conditioner : debounced buttons -> per-frame operation vector.
// Optional auto-repeat on RIGHT/LEFT/DOWN under macro INPUT_AUTOREPEAT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module input_conditioner
    import tetris_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [5:0]  REPEAT_DELAY    = 6'd12,
    parameter logic [5:0]  REPEAT_RATE     = 6'd3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               vsync,
    output logic [NUM_BTN-1:0] operation,
    output logic               frame_tick
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_repeat;
    logic [NUM_BTN-1:0] w_events;
    logic               w_latch;

    logic               r_vs_sync1;
    logic               r_vs_sync2;
    logic               r_vs_prev;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_operation;
    logic               r_frame_tick;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(w_level[i]),
            .press(w_press[i])
        );
    end

    assign w_latch = r_vs_sync2 & ~r_vs_prev;

`ifdef INPUT_AUTOREPEAT_EN
    // RIGHT, LEFT and DOWN occupy the low bits, so repeat covers [DOWN:0].
    localparam int NUM_REP = DOWN + 1;

    for (genvar i = 0; i < NUM_REP; i++) begin : g_repeat
        logic [5:0] r_count;
        logic [5:0] w_next;
        logic       w_hit;

        assign w_next = (r_count == 6'h3f) ? r_count : r_count + 6'd1;
        assign w_hit  = w_latch & w_level[i] & ~w_press[i] & (w_next == REPEAT_DELAY);
        assign w_repeat[i] = w_hit;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_count <= 6'd0;
            end else if (w_press[i] || !w_level[i]) begin
                r_count <= 6'd0;
            end else if (w_latch) begin
                r_count <= w_hit ? (REPEAT_DELAY - REPEAT_RATE) : w_next;
            end
        end
    end

    assign w_repeat[NUM_BTN-1:NUM_REP] = '0;
`else
    logic w_unused_repeat_cfg;

    assign w_repeat            = '0;
    assign w_unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    assign w_events = w_press | w_repeat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vs_sync1   <= 1'b0;
            r_vs_sync2   <= 1'b0;
            r_vs_prev    <= 1'b0;
            r_pending    <= '0;
            r_operation  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_sync1   <= vsync;
            r_vs_sync2   <= r_vs_sync1;
            r_vs_prev    <= r_vs_sync2;
            r_frame_tick <= w_latch;
            if (w_latch) begin
                // Events arriving on the latch cycle seed the next frame's pending.
                r_operation <= filter_lateral(r_pending);
                r_pending   <= w_events;
            end else begin
                r_pending   <= r_pending | w_events;
            end
        end
    end

    assign operation  = r_operation;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire
